// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: control-bundle pipeline (RegWrite, ResultSrc, MemWrite,
// Rd, valid) over DEPTH stage registers. Each stage supports stall and flush.
// Two combinational hazard-query ports report the youngest stage that writes
// a queried register, and whether that stage holds a load.
module pipe_ctrl_chain #(
   parameter int DEPTH = 2,
   parameter int RSW   = 2,
   parameter int RDW   = 5,
   parameter int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 reg_write_in,
   input  logic [RSW-1:0]       result_src_in,
   input  logic                 mem_write_in,
   input  logic [RDW-1:0]       rd_in,
   input  logic [DEPTH-1:0]     stall,
   input  logic [DEPTH-1:0]     flush,
   output logic [DEPTH-1:0]     valid_o,
   output logic [DEPTH-1:0]     reg_write_o,
   output logic [DEPTH*RSW-1:0] result_src_o,
   output logic [DEPTH-1:0]     mem_write_o,
   output logic [DEPTH*RDW-1:0] rd_o,
   input  logic [RDW-1:0]       q_rs_a,
   input  logic [RDW-1:0]       q_rs_b,
   output logic                 hit_a,
   output logic [SW-1:0]        hit_stage_a,
   output logic                 hit_load_a,
   output logic                 hit_b,
   output logic [SW-1:0]        hit_stage_b,
   output logic                 hit_load_b
);

   // Effective hold: a stage is held if it or any older stage stalls.
   logic [DEPTH-1:0] hold;

   for (genvar k = 0; k < DEPTH; k++) begin : g_hold
      assign hold[k] = |stall[DEPTH-1:k];
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      // Upstream view: inputs for stage 0, the previous stage otherwise.
      logic           up_hold;
      logic           up_valid;
      logic           up_reg_write;
      logic [RSW-1:0] up_result_src;
      logic           up_mem_write;
      logic [RDW-1:0] up_rd;

      logic           valid_d, valid_q;
      logic           reg_write_d, reg_write_q;
      logic [RSW-1:0] result_src_d, result_src_q;
      logic           mem_write_d, mem_write_q;
      logic [RDW-1:0] rd_d, rd_q;

      if (k == 0) begin : g_head
         assign up_hold       = 1'b0;
         assign up_valid      = in_valid;
         assign up_reg_write  = reg_write_in;
         assign up_result_src = result_src_in;
         assign up_mem_write  = mem_write_in;
         assign up_rd         = rd_in;
      end else begin : g_body
         assign up_hold       = hold[k-1];
         assign up_valid      = valid_o[k-1];
         assign up_reg_write  = reg_write_o[k-1];
         assign up_result_src = result_src_o[(k-1)*RSW +: RSW];
         assign up_mem_write  = mem_write_o[k-1];
         assign up_rd         = rd_o[(k-1)*RDW +: RDW];
      end

      // Next state: flush > hold > bubble-behind-held-stage > advance.
      // An invalid upstream entry always lands as an all-zero bubble.
      always_comb begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         result_src_d = '0;
         mem_write_d  = 1'b0;
         rd_d         = '0;
         if (flush[k]) begin
            valid_d = 1'b0;
         end else if (hold[k]) begin
            valid_d      = valid_q;
            reg_write_d  = reg_write_q;
            result_src_d = result_src_q;
            mem_write_d  = mem_write_q;
            rd_d         = rd_q;
         end else if (!up_hold && up_valid) begin
            valid_d      = 1'b1;
            reg_write_d  = up_reg_write;
            result_src_d = up_result_src;
            mem_write_d  = up_mem_write;
            rd_d         = up_rd;
         end
      end

      // Stage register with synchronous active-low reset to a bubble.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            mem_write_q  <= 1'b0;
            rd_q         <= '0;
         end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            rd_q         <= rd_d;
         end
      end

      assign valid_o[k]                  = valid_q;
      assign reg_write_o[k]              = reg_write_q;
      assign result_src_o[k*RSW +: RSW]  = result_src_q;
      assign mem_write_o[k]              = mem_write_q;
      assign rd_o[k*RDW +: RDW]          = rd_q;
   end

   // Returns {hit, stage, load}; scanning old->young lets the youngest
   // (most recent) writer win. x0 never matches.
   function automatic logic [SW+1:0] query(input logic [RDW-1:0] q);
      logic          hit;
      logic [SW-1:0] stg;
      logic          ld;
      hit = 1'b0;
      stg = '0;
      ld  = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (valid_o[k] && reg_write_o[k] && (rd_o[k*RDW +: RDW] == q) && (q != '0)) begin
            hit = 1'b1;
            stg = SW'(k);
            ld  = (result_src_o[k*RSW +: RSW] == RSW'(1));
         end
      end
      return {hit, stg, ld};
   endfunction

   // Two independent hazard-query ports over stored state only.
   always_comb begin
      {hit_a, hit_stage_a, hit_load_a} = query(q_rs_a);
      {hit_b, hit_stage_b, hit_load_b} = query(q_rs_b);
   end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with
// the clock edge they apply to; a monitor pops and compares after that edge.
module tb_pipe_ctrl_chain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DEPTH=2 instance
   logic       a_rst_n, a_iv, a_rw, a_mw;
   logic [1:0] a_rs, a_stall, a_flush;
   logic [4:0] a_rd, a_qa, a_qb;
   logic [1:0] a_valid, a_rwo, a_mwo;
   logic [3:0] a_rso;
   logic [9:0] a_rdo;
   logic       a_hit_a, a_st_a, a_ld_a, a_hit_b, a_st_b, a_ld_b;

   pipe_ctrl_chain #(.DEPTH(2)) dut2 (
      .clk(clk), .rst_n(a_rst_n), .in_valid(a_iv), .reg_write_in(a_rw),
      .result_src_in(a_rs), .mem_write_in(a_mw), .rd_in(a_rd),
      .stall(a_stall), .flush(a_flush),
      .valid_o(a_valid), .reg_write_o(a_rwo), .result_src_o(a_rso),
      .mem_write_o(a_mwo), .rd_o(a_rdo),
      .q_rs_a(a_qa), .q_rs_b(a_qb),
      .hit_a(a_hit_a), .hit_stage_a(a_st_a), .hit_load_a(a_ld_a),
      .hit_b(a_hit_b), .hit_stage_b(a_st_b), .hit_load_b(a_ld_b));

   // DEPTH=4 instance
   logic        b_rst_n, b_iv, b_rw, b_mw;
   logic [1:0]  b_rs;
   logic [3:0]  b_stall, b_flush;
   logic [4:0]  b_rd, b_qa, b_qb;
   logic [3:0]  b_valid, b_rwo, b_mwo;
   logic [7:0]  b_rso;
   logic [19:0] b_rdo;
   logic        b_hit_a, b_ld_a, b_hit_b, b_ld_b;
   logic [1:0]  b_st_a, b_st_b;

   pipe_ctrl_chain #(.DEPTH(4)) dut4 (
      .clk(clk), .rst_n(b_rst_n), .in_valid(b_iv), .reg_write_in(b_rw),
      .result_src_in(b_rs), .mem_write_in(b_mw), .rd_in(b_rd),
      .stall(b_stall), .flush(b_flush),
      .valid_o(b_valid), .reg_write_o(b_rwo), .result_src_o(b_rso),
      .mem_write_o(b_mwo), .rd_o(b_rdo),
      .q_rs_a(b_qa), .q_rs_b(b_qb),
      .hit_a(b_hit_a), .hit_stage_a(b_st_a), .hit_load_a(b_ld_a),
      .hit_b(b_hit_b), .hit_stage_b(b_st_b), .hit_load_b(b_ld_b));

   // kind: 0 = dut2 stage, 1 = dut2 query, 2 = dut4 stage, 3 = dut4 query
   typedef struct {
      int          tgt;
      string       nm;
      int          kind;
      int          stg;
      logic [15:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [15:0] sw(input logic v, input logic rw, input logic [1:0] rs,
                                      input logic mw, input logic [4:0] rd);
      return {6'b0, v, rw, rs, mw, rd};
   endfunction

   function automatic logic [15:0] qw2(input logic ha, input logic sa, input logic la,
                                       input logic hb, input logic sb, input logic lb);
      return {10'b0, ha, sa, la, hb, sb, lb};
   endfunction

   function automatic logic [15:0] qw4(input logic ha, input logic [1:0] sa, input logic la,
                                       input logic hb, input logic [1:0] sb, input logic lb);
      return {8'b0, ha, sa, la, hb, sb, lb};
   endfunction

   function automatic logic [15:0] actual(input int kind, input int k);
      case (kind)
         0:       return {6'b0, a_valid[k], a_rwo[k], a_rso[k*2 +: 2], a_mwo[k], a_rdo[k*5 +: 5]};
         1:       return {10'b0, a_hit_a, a_st_a, a_ld_a, a_hit_b, a_st_b, a_ld_b};
         2:       return {6'b0, b_valid[k], b_rwo[k], b_rso[k*2 +: 2], b_mwo[k], b_rdo[k*5 +: 5]};
         default: return {8'b0, b_hit_a, b_st_a, b_ld_a, b_hit_b, b_st_b, b_ld_b};
      endcase
   endfunction

   // Expectation for the state after the next rising edge.
   task automatic es(input string nm, input int kind, input int k, input logic [15:0] w);
      exp_t e;
      e.tgt = cyc + 1; e.nm = nm; e.kind = kind; e.stg = k; e.exp = w;
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drv2(input logic rst, input logic iv, input logic rw, input logic [1:0] rs,
                       input logic mw, input logic [4:0] rd, input logic [1:0] st,
                       input logic [1:0] fl, input logic [4:0] qa, input logic [4:0] qb);
      a_rst_n = rst; a_iv = iv; a_rw = rw; a_rs = rs; a_mw = mw; a_rd = rd;
      a_stall = st; a_flush = fl; a_qa = qa; a_qb = qb;
   endtask

   task automatic drv4(input logic rst, input logic iv, input logic rw, input logic [1:0] rs,
                       input logic mw, input logic [4:0] rd, input logic [4:0] qa, input logic [4:0] qb);
      b_rst_n = rst; b_iv = iv; b_rw = rw; b_rs = rs; b_mw = mw; b_rd = rd;
      b_stall = '0; b_flush = '0; b_qa = qa; b_qb = qb;
   endtask

   // Monitor: after each edge, compare every expectation targeted at it.
   exp_t        me;
   logic [15:0] mact;
   initial begin
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
            me   = sbq.pop_front();
            mact = actual(me.kind, me.stg);
            checks++;
            if (mact !== me.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", me.nm, mact, me.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drv4(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Reset with all inputs at 1
      drv2(0, 1, 1, 2'b11, 1, 5'd31, 2'b11, 2'b11, 5'd31, 5'd31);
      es("rst_s0", 0, 0, '0); es("rst_s1", 0, 1, '0); es("rst_q", 1, 0, '0); tick();
      // First instruction rd=5 load
      drv2(1, 1, 1, 2'b01, 0, 5'd5, 2'b00, 2'b00, 5'd5, 5'd0);
      es("ld5_s0", 0, 0, sw(1, 1, 1, 0, 5)); es("ld5_s1", 0, 1, '0);
      es("ld5_q", 1, 0, qw2(1, 0, 1, 0, 0, 0)); tick();
      drv2(1, 1, 1, 2'b00, 0, 5'd6, 2'b00, 2'b00, 5'd5, 5'd6);
      es("adv_s0", 0, 0, sw(1, 1, 0, 0, 6)); es("adv_s1", 0, 1, sw(1, 1, 1, 0, 5));
      es("adv_q", 1, 0, qw2(1, 1, 1, 1, 0, 0)); tick();
      // Stall oldest stage for two cycles: both stages hold
      drv2(1, 1, 1, 2'b00, 0, 5'd7, 2'b10, 2'b00, 5'd0, 5'd0);
      es("st10a_s0", 0, 0, sw(1, 1, 0, 0, 6)); es("st10a_s1", 0, 1, sw(1, 1, 1, 0, 5)); tick();
      es("st10b_s0", 0, 0, sw(1, 1, 0, 0, 6)); es("st10b_s1", 0, 1, sw(1, 1, 1, 0, 5)); tick();
      // Stall youngest: stage0 holds, stage1 gets a bubble
      drv2(1, 1, 0, 2'b10, 1, 5'd7, 2'b01, 2'b00, 5'd0, 5'd0);
      es("st01_s0", 0, 0, sw(1, 1, 0, 0, 6)); es("st01_s1", 0, 1, '0); tick();
      // Build stage0 {3,01} over stage1 {3,00}
      drv2(1, 1, 1, 2'b00, 0, 5'd3, 2'b00, 2'b00, 5'd0, 5'd0);
      es("fill_s0", 0, 0, sw(1, 1, 0, 0, 3)); es("fill_s1", 0, 1, sw(1, 1, 0, 0, 6)); tick();
      drv2(1, 1, 1, 2'b01, 0, 5'd3, 2'b00, 2'b00, 5'd3, 5'd6);
      es("prio_s0", 0, 0, sw(1, 1, 1, 0, 3)); es("prio_s1", 0, 1, sw(1, 1, 0, 0, 3));
      es("prio_q", 1, 0, qw2(1, 0, 1, 0, 0, 0)); tick();
      // Flush stage0 while stage1 is held: older writer now wins, not a load
      drv2(1, 1, 1, 2'b00, 0, 5'd9, 2'b10, 2'b01, 5'd3, 5'd3);
      es("fl0_s0", 0, 0, '0); es("fl0_s1", 0, 1, sw(1, 1, 0, 0, 3));
      es("fl0_q", 1, 0, qw2(1, 1, 0, 1, 1, 0)); tick();
      // Flush beats stall in stage0; stage1 takes the bubble behind the stall
      drv2(1, 1, 1, 2'b10, 1, 5'd12, 2'b00, 2'b00, 5'd0, 5'd0);
      es("pre_s0", 0, 0, sw(1, 1, 2, 1, 12)); tick();
      drv2(1, 1, 0, 2'b00, 1, 5'd13, 2'b00, 2'b00, 5'd0, 5'd0);
      es("pre2_s1", 0, 1, sw(1, 1, 2, 1, 12)); tick();
      drv2(1, 1, 1, 2'b01, 0, 5'd14, 2'b01, 2'b01, 5'd13, 5'd12);
      es("flst_s0", 0, 0, '0); es("flst_s1", 0, 1, '0); es("flst_q", 1, 0, '0); tick();
      // x0 never hits
      drv2(1, 1, 1, 2'b00, 0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0);
      es("x0_s0", 0, 0, sw(1, 1, 0, 0, 0)); es("x0_q", 1, 0, '0); tick();
      // in_valid=0 loads a bubble regardless of control inputs
      drv2(1, 0, 1, 2'b01, 1, 5'd9, 2'b00, 2'b00, 5'd0, 5'd9);
      es("inv_s0", 0, 0, '0); es("inv_s1", 0, 1, sw(1, 1, 0, 0, 0)); es("inv_q", 1, 0, '0); tick();
      // Fill then reset under full stall
      drv2(1, 1, 1, 2'b01, 1, 5'd21, 2'b00, 2'b00, 5'd0, 5'd0);
      es("f21_s0", 0, 0, sw(1, 1, 1, 1, 21)); tick();
      drv2(1, 1, 1, 2'b11, 0, 5'd22, 2'b00, 2'b00, 5'd21, 5'd22);
      es("f22_s0", 0, 0, sw(1, 1, 3, 0, 22)); es("f22_s1", 0, 1, sw(1, 1, 1, 1, 21));
      es("f22_q", 1, 0, qw2(1, 1, 1, 1, 0, 0)); tick();
      drv2(0, 1, 1, 2'b01, 1, 5'd23, 2'b11, 2'b00, 5'd21, 5'd22);
      es("mrst_s0", 0, 0, '0); es("mrst_s1", 0, 1, '0); es("mrst_q", 1, 0, '0); tick();
      drv2(1, 0, 0, 2'b00, 0, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0);
      es("post_s0", 0, 0, '0); es("post_s1", 0, 1, '0); tick();

      // DEPTH=4: reset, then a 4-instruction stream emerges in order at stage 3
      drv4(0, 1, 1, 2'b11, 1, 5'd31, 5'd0, 5'd0);
      for (int k = 0; k < 4; k++) es("d4_rst", 2, k, '0);
      tick();
      drv4(1, 1, 1, 2'b01, 1, 5'd1, 5'd0, 5'd0); tick();
      drv4(1, 1, 1, 2'b10, 0, 5'd2, 5'd0, 5'd0); tick();
      drv4(1, 1, 1, 2'b11, 1, 5'd3, 5'd0, 5'd0); tick();
      drv4(1, 1, 1, 2'b00, 0, 5'd4, 5'd2, 5'd1);
      es("d4_i1_s3", 2, 3, sw(1, 1, 1, 1, 1)); es("d4_i4_s0", 2, 0, sw(1, 1, 0, 0, 4));
      es("d4_q", 3, 0, qw4(1, 2'd2, 0, 1, 2'd3, 1)); tick();
      drv4(1, 0, 0, 2'b00, 0, 5'd0, 5'd0, 5'd0);
      es("d4_i2_s3", 2, 3, sw(1, 1, 2, 0, 2)); tick();
      es("d4_i3_s3", 2, 3, sw(1, 1, 3, 1, 3)); tick();
      es("d4_i4_s3", 2, 3, sw(1, 1, 0, 0, 4)); tick();
      es("d4_end_s3", 2, 3, '0); tick();

      tick(); tick();
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
